// File: rtl/sprite_pop_pkg.sv
// Shared types and constants for the pop-cat sheet sequencer.
package sprite_pop_pkg;

  // Sheet-select sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POP   = 2'd2
  } pop_state_t;

  // Hold counter is wide enough for any legal HOLD_FRAMES (1..255).
  localparam int HOLD_W = $clog2(256);

endpackage

// File: rtl/sprite_pop_controller_if.sv
// Board-side bundle of the pop controller: button and frame strobe in,
// sheet select, pop strobe and score count out.
interface sprite_pop_controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   btn_in;
  logic                   new_frame_in;
  logic                   pop_out;
  logic                   pop_pulse_out;
  logic [COUNT_WIDTH-1:0] pop_count_out;

  // Board / frame-timing side.
  modport master (
    output btn_in,
    output new_frame_in,
    input  pop_out,
    input  pop_pulse_out,
    input  pop_count_out
  );

  // Controller side.
  modport slave (
    input  btn_in,
    input  new_frame_in,
    output pop_out,
    output pop_pulse_out,
    output pop_count_out
  );
endinterface

// File: rtl/sprite_pop_controller_debouncer.sv
// Pushbutton conditioner: synchronizes the raw button, filters bounce and
// reports the debounced level plus a one-cycle pulse on each press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 74250
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             synced;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;

  synchronizer #(
    .DEPTH(2),
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_raw),
    .q  (synced)
  );

  // Count consecutive cycles of disagreement; flip the level once it lasts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (synced == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= synced;
        rise_reg  <= synced;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/synchronizer.sv
// Multi-stage flop synchronizer for bringing asynchronous levels into clk.
module synchronizer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

  // Shift the sampled value through the stage chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/sprite_pop_controller.sv
// Drives the sprite renderer's sheet select from the pushbutton. Sheet
// changes only take effect right after a frame strobe, the popped sheet is
// held for a minimum number of frames, and pops are counted for the score.
module sprite_pop_controller
  import sprite_pop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 74250,
  parameter int HOLD_FRAMES     = 6,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  sprite_pop_controller_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic                   level;
  logic                   press;
  pop_state_t             state_reg;
  pop_state_t             state_next;
  logic [HOLD_W-1:0]      hold_reg;
  logic [HOLD_W-1:0]      hold_next;
  logic                   pending_reg;
  logic                   pending_next;
  logic                   consume;
  logic                   pop_reg;
  logic                   pulse_reg;
  logic [COUNT_WIDTH-1:0] count_reg;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (pixel_clk_in),
    .rst    (rst_in),
    .btn_raw(bus.btn_in),
    .level  (level),
    .rise   (press)
  );

  // Next-state logic; every sheet change is gated by the frame strobe.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    consume    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (bus.new_frame_in) begin
          state_next = POP;
          hold_next  = HOLD_LOAD;
          consume    = 1'b1;
        end
      end
      POP: begin
        if (bus.new_frame_in) begin
          if (pending_reg) begin
            hold_next = HOLD_LOAD;
            consume   = 1'b1;
          end else if (hold_reg > HOLD_ONE) begin
            hold_next = hold_reg - HOLD_ONE;
          end else if (level) begin
            // A held button keeps the cat popped one frame at a time.
            hold_next = HOLD_ONE;
          end else begin
            state_next = IDLE;
            hold_next  = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = '0;
      end
    endcase
    // A press landing in the consuming cycle belongs to the next frame.
    pending_next = press | (pending_reg & ~consume);
  end

  // State, pending flag and registered outputs.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      pending_reg <= 1'b0;
      pop_reg     <= 1'b0;
      pulse_reg   <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      pending_reg <= pending_next;
      pop_reg     <= (state_next == POP);
      pulse_reg   <= consume;
      if (consume) begin
        count_reg <= count_reg + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.pop_out       = pop_reg;
  assign bus.pop_pulse_out = pulse_reg;
  assign bus.pop_count_out = count_reg;

endmodule

// File: tb/tb_sprite_pop_controller.sv
// Self-checking bench for sprite_pop_controller: per-cycle reference model,
// table-driven button scenarios, count wrap, async reset and random bouncing.
module tb_sprite_pop_controller;

  localparam int DEB   = 8;
  localparam int HOLD  = 3;
  localparam int CW    = 4;
  localparam int FRAME = 50;
  localparam int WIN   = 450;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sprite_pop_controller_if #(.COUNT_WIDTH(CW)) bus_if ();

  sprite_pop_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_FRAMES    (HOLD),
    .COUNT_WIDTH    (CW)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in      (rst),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n      = 0;
  int exp_count = 0;

  // Reference model state (spec-level view of the controller).
  bit m_hist[$];
  bit m_level;
  int m_run;
  bit m_press;
  bit m_pending;
  bit m_waiting;
  bit m_up;
  int m_frames;
  bit m_pulse;
  int m_count;

  typedef struct {
    int off;
    int la;
    int sb;
    int lb;
    int exp_high;
    int exp_pulses;
    int exp_rises;
    int exp_delay;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp, n);
    end
  endtask

  function automatic void model_reset();
    m_hist.delete();
    m_level = 0; m_run = 0; m_press = 0; m_pending = 0;
    m_waiting = 0; m_up = 0; m_frames = 0; m_pulse = 0; m_count = 0;
  endfunction

  // One clock edge of the behavioural model.
  function automatic void model_edge(input bit btn, input bit nf);
    bit synced, lvl_old, press_old, took;
    m_hist.push_back(btn);
    synced = 1'b0;
    if (m_hist.size() > 2) synced = m_hist.pop_front();
    lvl_old   = m_level;
    press_old = m_press;
    took      = 1'b0;
    m_pulse   = 1'b0;
    if (m_waiting) begin
      if (nf) begin
        m_waiting = 0; m_up = 1; m_frames = HOLD; took = 1;
      end
    end else if (m_up) begin
      if (nf) begin
        if (m_pending) begin
          m_frames = HOLD; took = 1;
        end else if (m_frames > 1) begin
          m_frames--;
        end else if (!lvl_old) begin
          m_up = 0;
        end
      end
    end else if (m_pending) begin
      m_waiting = 1;
    end
    if (took) begin
      m_pulse = 1;
      m_count = (m_count + 1) % (1 << CW);
    end
    m_pending = press_old || (m_pending && !took);
    m_press = 0;
    if (synced == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_level = synced; m_run = 0; m_press = synced;
      end
    end
  endfunction

  // Apply one cycle of inputs, advance model, check outputs mid-cycle.
  task automatic step(input bit btn);
    bit nf;
    nf = ((n % FRAME) == 0);
    bus_if.btn_in       = btn;
    bus_if.new_frame_in = nf;
    @(posedge clk);
    model_edge(btn, nf);
    @(negedge clk);
    check("pop_out", bus_if.pop_out, m_up);
    check("pop_pulse_out", bus_if.pop_pulse_out, m_pulse);
    check("pop_count_out", bus_if.pop_count_out, m_count);
    n++;
  endtask

  task automatic align(input int off);
    while ((n % FRAME) != off) step(1'b0);
  endtask

  task automatic run_window(input int la, input int sb, input int lb, input int w,
                            output int high, output int pulses, output int rises,
                            output int first);
    bit prev;
    prev = 1'b0; high = 0; pulses = 0; rises = 0; first = -1;
    for (int i = 0; i < w; i++) begin
      step((i < la) || (i >= sb && i < sb + lb));
      if (bus_if.pop_out === 1'b1) begin
        high++;
        if (first < 0) first = i;
        if (!prev) rises++;
      end
      if (bus_if.pop_pulse_out === 1'b1) pulses++;
      prev = (bus_if.pop_out === 1'b1);
    end
  endtask

  initial begin
    int high, pulses, rises, first, seg;
    bit lvl;

    // off, tap A len, tap B start, tap B len, high cycles, pulses, rises, delay
    vecs[0] = '{1,  20,   0,  0, 150, 1, 1, 49};  // short tap
    vecs[1] = '{1,  300,  0,  0, 300, 1, 1, 49};  // held button
    vecs[2] = '{1,  5,    0,  0, 0,   0, 0, -1};  // glitch
    vecs[3] = '{1,  7,    0,  0, 0,   0, 0, -1};  // one short of debounce
    vecs[4] = '{20, 12,   0,  0, 150, 1, 1, 30};  // press mid-frame
    vecs[5] = '{40, 20,   0,  0, 150, 1, 1, 60};  // press coincides with frame
    vecs[6] = '{1,  20, 110, 20, 250, 2, 1, 49};  // retrigger at hold=2
    vecs[7] = '{1,  12,  25, 12, 150, 1, 1, 49};  // two presses in one frame

    bus_if.btn_in       = 1'b0;
    bus_if.new_frame_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pop_out", bus_if.pop_out, 0);
    check("reset pop_pulse_out", bus_if.pop_pulse_out, 0);
    check("reset pop_count_out", bus_if.pop_count_out, 0);
    rst = 1'b0;
    model_reset();

    for (int v = 0; v < 8; v++) begin
      align(vecs[v].off);
      run_window(vecs[v].la, vecs[v].sb, vecs[v].lb, WIN, high, pulses, rises, first);
      exp_count = (exp_count + vecs[v].exp_pulses) % (1 << CW);
      $display("vec %0d: high=%0d pulses=%0d rises=%0d delay=%0d count=%0d",
               v, high, pulses, rises, first, bus_if.pop_count_out);
      check($sformatf("vec%0d high", v), high, vecs[v].exp_high);
      check($sformatf("vec%0d pulses", v), pulses, vecs[v].exp_pulses);
      check($sformatf("vec%0d rises", v), rises, vecs[v].exp_rises);
      check($sformatf("vec%0d delay", v), first, vecs[v].exp_delay);
      check($sformatf("vec%0d count", v), bus_if.pop_count_out, exp_count);
    end

    // Seventeen separate pops carry the 4-bit counter through its wrap.
    align(1);
    for (int k = 1; k <= 17; k++) begin
      run_window(20, 0, 0, 200, high, pulses, rises, first);
      exp_count = (exp_count + 1) % (1 << CW);
      $display("wrap pop %0d: count=%0d", k, bus_if.pop_count_out);
      check("wrap count", bus_if.pop_count_out, exp_count);
      check("wrap high", high, 150);
    end

    // Async reset in POP with a press still pending and the button held.
    align(1);
    run_window(20, 80, 16, 96, high, pulses, rises, first);
    check("pre-reset pop_out", bus_if.pop_out, 1);
    #2 rst = 1'b1;
    #1;
    $display("async reset: pop=%0d count=%0d", bus_if.pop_out, bus_if.pop_count_out);
    check("async pop_out", bus_if.pop_out, 0);
    check("async pop_pulse_out", bus_if.pop_pulse_out, 0);
    check("async pop_count_out", bus_if.pop_count_out, 0);
    bus_if.new_frame_in = 1'b0;
    @(negedge clk);
    check("in-reset pop_out", bus_if.pop_out, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_window(200, 0, 0, 200, high, pulses, rises, first);
    $display("post-reset held: pulses=%0d first=%0d count=%0d", pulses, first, bus_if.pop_count_out);
    check("post-reset pulses", pulses, 1);
    check("post-reset count", bus_if.pop_count_out, 1);
    check("post-reset not early", (first >= DEB + 2) ? 1 : 0, 1);
    run_window(0, 0, 0, 300, high, pulses, rises, first);
    check("post-release pop_out", bus_if.pop_out, 0);

    // Random bouncing button checked cycle by cycle against the model.
    lvl = 1'b0;
    for (int r = 0; r < 40; r++) begin
      seg = $urandom_range(1, 60);
      lvl = ~lvl;
      for (int i = 0; i < seg; i++) step(lvl);
      $display("random seg %0d: btn=%0d len=%0d pop=%0d count=%0d",
               r, lvl, seg, bus_if.pop_out, bus_if.pop_count_out);
    end
    for (int i = 0; i < 400; i++) step(1'b0);
    check("random settle pop_out", bus_if.pop_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
